// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default width for the mul/div unit
package muldiv_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring radix-2 divider on magnitudes, one quotient bit per cycle
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_last,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);
  localparam int CW = $clog2(XLEN);
  logic [XLEN-1:0] r_rem, r_quot, r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic [XLEN:0]   w_shift, w_diff;
  logic            w_ge;
  // o_quot/o_rem are the post-step values so the caller can capture the final step directly
  assign w_shift = {r_rem, r_quot[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = !w_diff[XLEN];
  assign o_rem   = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign o_quot  = {r_quot[XLEN-2:0], w_ge};
  assign o_busy  = r_busy;
  assign o_last  = r_busy && r_cnt == CW'(XLEN-1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dvs  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= o_rem;
      r_quot <= o_quot;
      r_cnt  <= o_last ? '0 : r_cnt + CW'(1);
      r_busy <= !o_last;
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV-M style multiply/divide unit, single-cycle multiply, iterative divide
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OPW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_e            r_state, w_nxt;
  op_e               r_op;
  logic [XLEN-1:0]   r_a, r_b, r_result;
  logic              r_zero;
  logic              w_accept, w_busy, w_last, w_setup, w_special, w_start;
  logic              w_mul_sa, w_mul_sb, w_div_sgn, w_an, w_bn, w_b_zero, w_ovf;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_quot, w_rem, w_q, w_r, w_mul_res, w_div_res, w_res;
  assign in_ready  = r_state == S_IDLE;
  assign out_valid = r_state == S_DONE;
  assign result    = r_result;
  assign zero      = r_zero;
  assign w_accept  = in_valid && in_ready && !flush;
  assign w_mul_sa  = r_op != OP_MULHU;
  assign w_mul_sb  = r_op == OP_MUL || r_op == OP_MULH;
  assign w_prod    = {{XLEN{w_mul_sa & r_a[XLEN-1]}}, r_a} * {{XLEN{w_mul_sb & r_b[XLEN-1]}}, r_b};
  assign w_mul_res = r_op == OP_MUL ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
  assign w_div_sgn = r_op == OP_DIV || r_op == OP_REM;
  assign w_an      = w_div_sgn & r_a[XLEN-1];
  assign w_bn      = w_div_sgn & r_b[XLEN-1];
  assign w_a_mag   = w_an ? -r_a : r_a;
  assign w_b_mag   = w_bn ? -r_b : r_b;
  assign w_b_zero  = r_b == '0;
  assign w_ovf     = w_div_sgn && r_a == MIN_NEG && r_b == '1;
  assign w_special = w_b_zero || w_ovf;
  assign w_q       = w_b_zero ? '1 : w_ovf ? r_a : (w_an ^ w_bn) ? -w_quot : w_quot;
  assign w_r       = w_b_zero ? r_a : w_ovf ? '0 : w_an ? -w_rem : w_rem;
  assign w_div_res = (r_op == OP_REM || r_op == OP_REMU) ? w_r : w_q;
  assign w_res     = r_op[2] ? w_div_res : w_mul_res;
  // first DIV cycle loads the core (or resolves a special case); XLEN steps follow
  assign w_setup   = r_state == S_DIV && !w_busy;
  assign w_start   = w_setup && !w_special && !flush;
  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_abort   (flush),
    .i_dividend(w_a_mag),
    .i_divisor (w_b_mag),
    .o_busy    (w_busy),
    .o_last    (w_last),
    .o_quot    (w_quot),
    .o_rem     (w_rem)
  );
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  w_nxt = w_accept ? (op[2] ? S_DIV : S_MUL) : S_IDLE;
      S_MUL:   w_nxt = S_DONE;
      S_DIV:   w_nxt = ((w_setup && w_special) || w_last) ? S_DONE : S_DIV;
      default: w_nxt = S_IDLE;
    endcase
    if (flush) w_nxt = S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_op <= op_e'(op[2:0]);
        r_a  <= a;
        r_b  <= b;
      end
      if (w_nxt == S_DONE && r_state != S_DONE) begin
        r_result <= w_res;
        r_zero   <= w_res == '0;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  import muldiv_pkg::*;
  logic        clk, rst_n, in_valid, in_ready, flush, out_valid, zero;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  int tests = 0;
  int fails = 0;

  muldiv_unit #(.XLEN(32), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .flush(flush), .out_valid(out_valid), .result(result), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic ovf;
    ovf = x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    case (o)
      3'd0: begin p = longint'(int'(x)) * longint'(int'(y)); model = p[31:0]; end
      3'd1: begin p = longint'(int'(x)) * longint'(int'(y)); model = p[63:32]; end
      3'd2: begin p = longint'(int'(x)) * longint'({32'b0, y}); model = p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; model = p[63:32]; end
      3'd4: model = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'(int'(x) / int'(y));
      3'd5: model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: model = (y == 0) ? x : ovf ? 32'd0 : 32'(int'(x) % int'(y));
      default: model = (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (!o[2] || y == 0) return 2;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  // Presents one request, scrambles inputs after acceptance, waits (bounded) for the result.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output logic z, output int lat, output logic extra);
    res = 'x; z = 1'bx; lat = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n; res = result; z = zero;
        break;
      end
    end
    @(negedge clk);
    extra = out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset result: got %h exp 0", result); end
    tests++; if (zero !== 1'b1) begin fails++; $display("FAIL reset zero: got %b exp 1", zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul_directed;
    logic [2:0] ops [3];
    logic [31:0] exps [3];
    logic [31:0] res;
    logic z, ex;
    int lat;
    ops  = '{OP_MULH, OP_MULHU, OP_MUL};
    exps = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001};
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, z, lat, ex);
      tests++; if (res !== exps[i]) begin fails++; $display("FAIL mul op%0d result: got %h exp %h", ops[i], res, exps[i]); end
      tests++; if (lat !== 2) begin fails++; $display("FAIL mul op%0d latency: got %0d exp 2", ops[i], lat); end
      tests++; if (ex !== 1'b0) begin fails++; $display("FAIL mul op%0d strobe width: got %b exp 0", ops[i], ex); end
    end
  endtask

  task automatic test_div_directed;
    logic [2:0] ops [6];
    logic [31:0] xs [6], ys [6], exps [6];
    int lats [6];
    logic [31:0] res;
    logic z, ex;
    int lat;
    ops  = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    xs   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    ys   = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exps = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    lats = '{34, 34, 2, 2, 2, 2};
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], xs[i], ys[i], res, z, lat, ex);
      tests++; if (res !== exps[i]) begin fails++; $display("FAIL div case%0d result: got %h exp %h", i, res, exps[i]); end
      tests++; if (z !== (exps[i] == 0)) begin fails++; $display("FAIL div case%0d zero: got %b exp %b", i, z, exps[i] == 0); end
      tests++; if (lat !== lats[i]) begin fails++; $display("FAIL div case%0d latency: got %0d exp %0d", i, lat, lats[i]); end
      tests++; if (ex !== 1'b0) begin fails++; $display("FAIL div case%0d strobe width: got %b exp 0", i, ex); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] res;
    logic z, ex;
    int lat, seen;
    run_op(OP_MUL, 32'd3, 32'd5, res, z, lat, ex);
    tests++; if (res !== 32'd15) begin fails++; $display("FAIL flush pre-op: got %h exp %h", res, 32'd15); end
    @(negedge clk);
    op = OP_DIVU; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush in_ready: got %b exp 1", in_ready); end
    tests++; if (result !== 32'd15) begin fails++; $display("FAIL flush held result: got %h exp %h", result, 32'd15); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL flush stray out_valid: got %0d exp 0", seen); end
    run_op(OP_DIVU, 32'd100, 32'd7, res, z, lat, ex);
    tests++; if (res !== 32'd14) begin fails++; $display("FAIL flush divu: got %h exp %h", res, 32'd14); end
    run_op(OP_REMU, 32'd100, 32'd7, res, z, lat, ex);
    tests++; if (res !== 32'd2) begin fails++; $display("FAIL flush remu: got %h exp %h", res, 32'd2); end
  endtask

  task automatic test_flush_idle;
    int seen;
    @(negedge clk);
    op = OP_MUL; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle flush accepted: in_ready got %b exp 1", in_ready); end
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL idle flush out_valid: got %0d exp 0", seen); end
  endtask

  task automatic test_busy_ignore;
    logic [31:0] res;
    int lat, seen;
    res = 'x; lat = 0;
    @(negedge clk);
    op = OP_DIVU; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 op = OP_MUL; a = 32'd7; b = 32'd6;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (out_valid) begin lat = n; res = result; break; end
    end
    in_valid = 1'b0;
    tests++; if (res !== 32'd333) begin fails++; $display("FAIL busy ignore result: got %h exp %h", res, 32'd333); end
    tests++; if (lat !== 34) begin fails++; $display("FAIL busy ignore latency: got %0d exp 34", lat); end
    seen = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL busy ignore stray out_valid: got %0d exp 0", seen); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] res;
    logic z, ex;
    int lat, seen;
    @(negedge clk);
    op = OP_DIV; a = $urandom | 32'h1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset in_ready: got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset out_valid: got %b exp 0", out_valid); end
    tests++; if (result !== 32'd0) begin fails++; $display("FAIL midreset result: got %h exp 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midreset stray out_valid: got %0d exp 0", seen); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, z, lat, ex);
    tests++; if (res !== 32'hFFFF_FFFD) begin fails++; $display("FAIL midreset recovery: got %h exp %h", res, 32'hFFFF_FFFD); end
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic [31:0] x, y, exp_r, res;
    logic z, ex;
    int lat, exp_l;
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7)); x = $urandom; y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 15));
        3: y = -32'($urandom_range(1, 15));
        4: x = 32'($urandom_range(0, 3));
        default: ;
      endcase
      exp_r = model(o, x, y);
      exp_l = model_lat(o, x, y);
      run_op(o, x, y, res, z, lat, ex);
      tests++; if (res !== exp_r || z !== (exp_r == 0)) begin fails++; $display("FAIL rand op%0d a=%h b=%h: got %h/%b exp %h/%b", o, x, y, res, z, exp_r, exp_r == 0); end
      tests++; if (lat !== exp_l) begin fails++; $display("FAIL rand op%0d latency: got %0d exp %0d", o, lat, exp_l); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_flush();
    test_flush_idle();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >= 8).
REQ-002 SHALL have parameter OPW, default 3, op-code width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port op, input, OPW, operation select (encoding REQ-012).
REQ-008 SHALL have port a / b, input, XLEN each, rs1 / rs2 operands.
REQ-009 SHALL have port flush, input, 1, abandon in-flight operation.
REQ-010 SHALL have port out_valid, output, 1, one-cycle result strobe.
REQ-011 SHALL have ports result (output, XLEN, result) and zero (output, 1, result == 0).

Function
REQ-012 SHALL decode op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-013 SHALL accept a request when in_valid && in_ready && !flush, latching op, a and b.
REQ-014 SHALL drive in_ready = 1 only in state IDLE.
REQ-015 SHALL implement states IDLE, MUL, DIV, DONE; IDLE->MUL on accepted op 0xx; IDLE->DIV on accepted op 1xx.
REQ-016 SHALL make MUL take one cycle: MUL->DONE with the 2*XLEN product formed under the signedness of the op (MULHSU: a signed, b unsigned).
REQ-017 SHALL return product bits [XLEN-1:0] for MUL and bits [2*XLEN-1:XLEN] for MULH/MULHSU/MULHU.
REQ-018 SHALL divide by restoring radix-2 iteration on magnitudes, one quotient bit per cycle, exactly XLEN cycles in DIV, then DIV->DONE.
REQ-019 SHALL give DIV/REM quotient sign = sign(a) XOR sign(b), remainder sign = sign(a); truncation toward zero.
REQ-020 SHALL, for divisor 0, skip iteration (DIV->DONE after one cycle): quotient = all ones, remainder = a.
REQ-021 SHALL, for signed overflow (a = most negative, b = -1, DIV/REM), skip iteration: quotient = a, remainder = 0.
REQ-022 SHALL assert out_valid for exactly the one cycle spent in DONE; DONE->IDLE unconditionally.
REQ-023 SHALL register result and zero on entry to DONE and hold them until the next DONE.
REQ-024 SHALL give latency (accept edge to out_valid high): MUL* 2 cycles, special-case divide 2 cycles, normal divide XLEN+2 cycles.
REQ-025 SHALL, on flush in any state, go to IDLE next edge with no out_valid and result/zero unchanged.
REQ-026 SHALL ignore in_valid while in_ready = 0; flush together with in_valid in IDLE accepts nothing.
REQ-027 SHALL ignore input changes to a, b and op after acceptance.

Reset
REQ-028 SHALL, while rst_n = 0, force state IDLE, in_ready 1, out_valid 0, result 0, zero 1, iteration counter 0.
REQ-029 SHALL discard an operation in flight when reset is asserted, with no out_valid after release.
REQ-030 SHALL release reset so that the first accept is possible on the first rising edge with rst_n = 1.

Structure
REQ-031 SHALL place the op encoding, state encoding and the default XLEN in shared package muldiv_pkg.
REQ-032 SHALL contain one sub-module muldiv_div_core (restoring iteration: remainder/quotient registers, counter, step and done).
REQ-033 SHALL infer no latches; all combinational paths SHALL have full defaults.

Verification
REQ-034 SHALL check MULH with a = 0xFFFFFFFF, b = 0xFFFFFFFF -> result 0x00000000; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001; each with out_valid 2 cycles after accept.
REQ-035 SHALL check DIV with a = -7 (0xFFFFFFF9), b = 2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; out_valid XLEN+2 = 34 cycles after accept.
REQ-036 SHALL check DIVU a = 5, b = 0 -> 0xFFFFFFFF; REMU -> 5; zero = 0; latency 2 cycles.
REQ-037 SHALL check DIV a = 0x80000000, b = 0xFFFFFFFF -> 0x80000000; REM -> 0, zero = 1.
REQ-038 SHALL check flush at cycle 10 of a DIVU 100/7: no out_valid, in_ready = 1 next cycle, prior result held; then DIVU 100/7 -> 14, REMU -> 2.
REQ-039 SHALL check rst_n pulsed low mid-DIV: immediate in_ready = 1, out_valid 0, result 0; no stray out_valid afterwards.
